// File: rtl/fault_pkg.sv
// Shared definitions for the fault-injection campaign controller and the fault_mux cells.
package fault_pkg;

   // Ceiling log2 with a one-bit floor, so it can size ports for any parameter value.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(n)) w = w + 1;
      return w;
   endfunction

   localparam int unsigned NG_DEFAULT = 128;
   localparam int unsigned GID_W      = clog2_min1(NG_DEFAULT);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_APPLY   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_COMPARE = 3'd3,
      ST_REPORT  = 3'd4,
      ST_NEXT    = 3'd5,
      ST_DONE    = 3'd6
   } state_e;

endpackage

// File: rtl/fault_onehot_dec.sv
// Gate-ID to one-hot fault enable decoder; combinational, registered by the parent.
module fault_onehot_dec #(
   parameter int unsigned NG = 128,
   parameter int unsigned GW = 7
) (
   input  logic          en,
   input  logic [GW-1:0] gid,
   output logic [NG-1:0] onehot_c
);

   always_comb begin
      onehot_c = '0;
      if (en) onehot_c = NG'(1) << gid;
   end

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Stuck-at fault campaign sequencer: walks every (gid, value) fault, applies test vectors
// with early drop on the first mismatch, and streams one verdict per fault.
module fault_campaign_ctrl
   import fault_pkg::*;
#(
   parameter int unsigned NG     = 128,
   parameter int unsigned NV     = 16,
   parameter int unsigned DW     = 8,
   parameter int unsigned SETTLE = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic [NG-1:0]                 fault_en_bus,
   output logic                          fault_val,
   output logic [clog2_min1(NV)-1:0]     vec_idx,
   input  logic [DW-1:0]                 dut_out,
   input  logic [DW-1:0]                 gold_out,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [clog2_min1(NG)-1:0]     res_gid,
   output logic                          res_val,
   output logic                          res_detected,
   output logic [clog2_min1(2*NG+1)-1:0] cnt_detected,
   output logic [clog2_min1(2*NG+1)-1:0] cnt_masked
);

   localparam int unsigned GW = clog2_min1(NG);
   localparam int unsigned VW = clog2_min1(NV);
   localparam int unsigned CW = clog2_min1(2*NG+1);
   localparam int unsigned SW = clog2_min1(SETTLE+1);

   state_e        state_q, state_d;
   logic [GW-1:0] gid_q, gid_d;
   logic          val_q, val_d;
   logic [VW-1:0] vec_q, vec_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          det_q, det_d;
   logic [CW-1:0] cnt_det_q, cnt_det_d;
   logic [CW-1:0] cnt_mask_q, cnt_mask_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          res_valid_q, res_valid_d;
   logic [NG-1:0] fault_en_q, fault_en_d;
   logic          fault_val_q, fault_val_d;
   logic          fault_on_c;

   // Next state, datapath and registered-output values derived from the next state.
   always_comb begin
      state_d    = state_q;
      gid_d      = gid_q;
      val_d      = val_q;
      vec_d      = vec_q;
      settle_d   = settle_q;
      det_d      = det_q;
      cnt_det_d  = cnt_det_q;
      cnt_mask_d = cnt_mask_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_APPLY;
               gid_d      = '0;
               val_d      = 1'b0;
               vec_d      = '0;
               det_d      = 1'b0;
               cnt_det_d  = '0;
               cnt_mask_d = '0;
            end
         end
         ST_APPLY: begin
            settle_d = '0;
            state_d  = (SETTLE == 0) ? ST_COMPARE : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == SW'(SETTLE - 1)) state_d = ST_COMPARE;
            else                             settle_d = settle_q + SW'(1);
         end
         ST_COMPARE: begin
            if (dut_out != gold_out) begin
               det_d   = 1'b1;
               state_d = ST_REPORT;
            end else if (vec_q == VW'(NV - 1)) begin
               det_d   = 1'b0;
               state_d = ST_REPORT;
            end else begin
               vec_d   = vec_q + VW'(1);
               state_d = ST_APPLY;
            end
         end
         ST_REPORT: begin
            if (res_ready) begin
               if (det_q) cnt_det_d  = cnt_det_q + CW'(1);
               else       cnt_mask_d = cnt_mask_q + CW'(1);
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            vec_d = '0;
            det_d = 1'b0;
            if ((gid_q == GW'(NG - 1)) && val_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_APPLY;
               if (val_q) begin
                  gid_d = gid_q + GW'(1);
                  val_d = 1'b0;
               end else begin
                  val_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      fault_on_c  = (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_COMPARE);
      fault_val_d = fault_on_c & val_d;
      busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d      = (state_d == ST_DONE);
      res_valid_d = (state_d == ST_REPORT);
   end

   fault_onehot_dec #(.NG(NG), .GW(GW)) u_dec (
      .en       (fault_on_c),
      .gid      (gid_d),
      .onehot_c (fault_en_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gid_q       <= '0;
         val_q       <= 1'b0;
         vec_q       <= '0;
         settle_q    <= '0;
         det_q       <= 1'b0;
         cnt_det_q   <= '0;
         cnt_mask_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         res_valid_q <= 1'b0;
         fault_en_q  <= '0;
         fault_val_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gid_q       <= gid_d;
         val_q       <= val_d;
         vec_q       <= vec_d;
         settle_q    <= settle_d;
         det_q       <= det_d;
         cnt_det_q   <= cnt_det_d;
         cnt_mask_q  <= cnt_mask_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         res_valid_q <= res_valid_d;
         fault_en_q  <= fault_en_d;
         fault_val_q <= fault_val_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign fault_en_bus = fault_en_q;
   assign fault_val    = fault_val_q;
   assign vec_idx      = vec_q;
   assign res_valid    = res_valid_q;
   assign res_gid      = gid_q;
   assign res_val      = val_q;
   assign res_detected = det_q;
   assign cnt_detected = cnt_det_q;
   assign cnt_masked   = cnt_mask_q;

   a_fault_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(fault_en_bus));

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Randomized bench for fault_campaign_ctrl against a transaction-level verdict model.
module tb_fault_campaign_ctrl;

   localparam int NG0 = 4;
   localparam int NV0 = 4;
   localparam int GW0 = $clog2(NG0);
   localparam int VW0 = $clog2(NV0);
   localparam int CW0 = $clog2(2*NG0+1);
   localparam int NG3 = 8;
   localparam int GW3 = $clog2(NG3);
   localparam int CW3 = $clog2(2*NG3+1);

   typedef struct {
      int gid;
      int val;
      bit det;
      int vecs;
   } verdict_t;

   logic clk, rst, start0, start3, res_ready;

   logic busy0, done0, fval0, res_valid0, res_val0, res_det0;
   logic [NG0-1:0] fault_en0;
   logic [VW0-1:0] vec0;
   logic [GW0-1:0] res_gid0;
   logic [CW0-1:0] cnt_det0, cnt_mask0;
   logic [7:0]     dut_o0, gold0;
   logic           mis0;

   logic busy3, done3, fval3, res_valid3, res_val3, res_det3;
   logic [NG3-1:0] fault_en3;
   logic [1:0]     vec3;
   logic [GW3-1:0] res_gid3;
   logic [CW3-1:0] cnt_det3, cnt_mask3;
   logic [7:0]     dut_o3, gold3;
   logic           mis3;

   int n_checks = 0;
   int n_pass   = 0;
   bit hit0 [NG0][2][NV0];
   verdict_t exp_q[$];
   verdict_t mon_e;
   int act_cnt;
   int hit_phase;
   int phase3;
   logic [NG3+2:0] key3_prev;
   bit rec_on;
   int rec_q[$];

   fault_campaign_ctrl #(.NG(NG0), .NV(NV0), .DW(8), .SETTLE(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
      .fault_en_bus(fault_en0), .fault_val(fval0), .vec_idx(vec0),
      .dut_out(dut_o0), .gold_out(gold0), .res_valid(res_valid0), .res_ready(res_ready),
      .res_gid(res_gid0), .res_val(res_val0), .res_detected(res_det0),
      .cnt_detected(cnt_det0), .cnt_masked(cnt_mask0));

   fault_campaign_ctrl #(.NG(NG3), .NV(4), .DW(8), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
      .fault_en_bus(fault_en3), .fault_val(fval3), .vec_idx(vec3),
      .dut_out(dut_o3), .gold_out(gold3), .res_valid(res_valid3), .res_ready(res_ready),
      .res_gid(res_gid3), .res_val(res_val3), .res_detected(res_det3),
      .cnt_detected(cnt_det3), .cnt_masked(cnt_mask3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Faulty circuit model: output flips when the enabled fault hits the table at this vector.
   always_comb begin
      mis0 = 1'b0;
      for (int g = 0; g < NG0; g++)
         if (fault_en0[g] && hit0[g][fval0][vec0]) mis0 = 1'b1;
      gold0  = 8'(32'(vec0) * 29 + 7);
      dut_o0 = gold0 ^ {7'd0, mis0};
   end

   // Second circuit only misbehaves on fault (0,0), vector 2, at one chosen cycle of the window.
   always_comb begin
      mis3   = fault_en3[0] && !fval3 && (vec3 == 2'd2) && (phase3 == hit_phase);
      gold3  = 8'(32'(vec3) * 13 + 3);
      dut_o3 = gold3 ^ {mis3, 7'd0};
   end

   always @(negedge clk) begin
      if ({fault_en3, fval3, vec3} == key3_prev) phase3 <= phase3 + 1;
      else                                        phase3 <= 0;
      key3_prev <= {fault_en3, fval3, vec3};
      if (rec_on && fault_en3 != '0) rec_q.push_back(int'(vec3));
   end

   // Verdict monitor for the SETTLE=0 instance.
   always @(negedge clk) begin
      if (!rst) begin
         if (fault_en0 != '0) act_cnt++;
         if (res_valid0 && res_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_verdict", 32'(res_gid0), 32'hFFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("verdict_gid", 32'(res_gid0), 32'(mon_e.gid));
               check_eq("verdict_val", 32'(res_val0), 32'(mon_e.val));
               check_eq("verdict_det", 32'(res_det0), 32'(mon_e.det));
               check_eq("fault_active_cycles", 32'(act_cnt), 32'(2 * mon_e.vecs));
            end
            act_cnt = 0;
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b1;
      start0 = 1'b0;
      start3 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic build_model(output int n_det);
      int first;
      exp_q.delete();
      n_det = 0;
      for (int g = 0; g < NG0; g++)
         for (int v = 0; v < 2; v++) begin
            first = NV0;
            for (int k = NV0 - 1; k >= 0; k--) if (hit0[g][v][k]) first = k;
            exp_q.push_back('{gid: g, val: v, det: (first < NV0), vecs: (first < NV0) ? first + 1 : NV0});
            if (first < NV0) n_det++;
         end
   endtask

   // mode 0: ready always high, 1: random ready, 2: hold ready low over the first verdict.
   task automatic run_campaign0(input int mode, input bit poke);
      int n_det, n;
      logic [16:0] snap;
      build_model(n_det);
      act_cnt   = 0;
      res_ready = (mode != 2);
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      check_eq("start_state", 32'({busy0, done0, cnt_det0, cnt_mask0, vec0, res_valid0}),
               32'({1'b1, 1'b0, CW0'(0), CW0'(0), VW0'(0), 1'b0}));
      if (mode == 2) begin
         n = 0;
         while (!res_valid0 && n < 200) begin @(posedge clk); #1; n++; end
         check_eq("bp_wait_valid", 32'(res_valid0), 32'd1);
         snap = {res_valid0, res_gid0, res_val0, res_det0, fault_en0, cnt_det0, cnt_mask0};
         repeat (10) begin
            @(posedge clk); #1;
            check_eq("bp_hold", 32'({res_valid0, res_gid0, res_val0, res_det0, fault_en0,
                                      cnt_det0, cnt_mask0}), 32'(snap));
         end
         res_ready = 1'b1;
         @(posedge clk); #1;
         check_eq("bp_release_count", 32'(cnt_det0) + 32'(cnt_mask0), 32'd1);
         check_eq("bp_valid_drop", 32'(res_valid0), 32'd0);
      end
      n = 0;
      while (!done0 && n < 2000) begin
         if (mode == 1) res_ready = ($urandom_range(0, 3) != 0);
         start0 = (poke && n == 12);
         @(posedge clk); #1;
         n++;
      end
      start0    = 1'b0;
      res_ready = 1'b1;
      check_eq("campaign_timeout", 32'(n < 2000), 32'd1);
      check_eq("verdicts_left", 32'(exp_q.size()), 32'd0);
      check_eq("cnt_detected", 32'(cnt_det0), 32'(n_det));
      check_eq("cnt_masked", 32'(cnt_mask0), 32'(2 * NG0 - n_det));
      check_eq("done_state", 32'({done0, busy0, fault_en0, res_valid0}), 32'({1'b1, 1'b0, 4'd0, 1'b0}));
   endtask

   task automatic phase_test(input int hp, input bit exp_det);
      int n, nv;
      hit_phase = hp;
      res_ready = 1'b1;
      rec_q.delete();
      rec_on = 1'b1;
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      n = 0;
      while (!res_valid3 && n < 300) begin @(posedge clk); #1; n++; end
      rec_on = 1'b0;
      nv = exp_det ? 3 : 4;
      check_eq("s3_valid", 32'(res_valid3), 32'd1);
      check_eq("s3_verdict", 32'({res_gid3, res_val3, res_det3}), 32'({GW3'(0), 1'b0, exp_det}));
      check_eq("s3_active_cycles", 32'(rec_q.size()), 32'(5 * nv));
      for (int i = 0; i < rec_q.size() && i < 20; i++)
         check_eq("s3_vec_seq", 32'(rec_q[i]), 32'(i / 5));
      apply_reset();
   endtask

   task automatic reset_test();
      int n;
      hit_phase = 99;
      res_ready = 1'b1;
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      n = 0;
      while (!(fault_en3[5] && phase3 == 1) && n < 3000) begin @(negedge clk); #1; n++; end
      check_eq("rst_reach_gid5", 32'({fault_en3[5], busy3, cnt_mask3}), 32'({1'b1, 1'b1, CW3'(10)}));
      rst = 1'b1;
      #1;
      check_eq("rst_async_clear", 32'({fault_en3, fval3, busy3, res_valid3, cnt_mask3, cnt_det3}), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         check_eq("rst_quiet", 32'({res_valid3, busy3, done3, fault_en3}), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; start0 = 1'b0; start3 = 1'b0; res_ready = 1'b1;
      hit_phase = 99; rec_on = 1'b0; act_cnt = 0;
      foreach (hit0[g, v, k]) hit0[g][v][k] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_dut0", 32'({fault_en0, fval0, vec0, busy0, done0, res_valid0, res_gid0,
                                   res_val0, res_det0, cnt_det0, cnt_mask0}), 32'd0);
      check_eq("reset_dut3", 32'({fault_en3, fval3, vec3, busy3, done3, res_valid3, cnt_det3,
                                   cnt_mask3}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      phase_test(4, 1'b1);
      phase_test(3, 1'b0);
      reset_test();

      run_campaign0(0, 1'b0);
      hit0[2][1][1] = 1'b1;
      run_campaign0(0, 1'b1);
      hit0[2][1][1] = 1'b0;
      run_campaign0(2, 1'b0);
      repeat (3) begin
         foreach (hit0[g, v, k]) hit0[g][v][k] = ($urandom_range(0, 9) == 0);
         run_campaign0(1, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
      $fatal(1, "bench timeout");
   end

endmodule
